alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 93 +++++++++
 tb/tb_alu_exec_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// 32-bit execute-stage ALU with flags, registered result and branch adder.
// Result, flags and branch target are combinational; ALUout is registered.
module alu_exec_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic [5:0]  opcode,
    input  logic [31:0] pc,
    input  logic [15:0] imm,
    output logic [31:0] result,
    output logic        zeroFlag,
    output logic        carryFlag,
    output logic        negativeFlag,
    output logic        greaterThanFlag,
    output logic        lessThanFlag,
    output logic [31:0] ALUout,
    output logic [31:0] branchAddress
);

    typedef enum logic [5:0] {
        OP_AND  = 6'd0,
        OP_ADD  = 6'd1,
        OP_SUB  = 6'd2,
        OP_OR   = 6'd3,
        OP_XOR  = 6'd4,
        OP_SLL  = 6'd5,
        OP_SRL  = 6'd6,
        OP_SRA  = 6'd7,
        OP_CMP  = 6'd8,
        OP_PASS = 6'd9,
        OP_NOT  = 6'd10
    } alu_op_t;

    logic [32:0] sum;
    logic [32:0] diff;
    logic [4:0]  shamt;

    // 33-bit add/sub so the top bit carries the carry-out or the borrow
    always_comb begin
        sum   = {1'b0, operandA} + {1'b0, operandB};
        diff  = {1'b0, operandA} - {1'b0, operandB};
        shamt = operandB[4:0];
    end

    // Operation select; undefined opcodes yield zero with no carry
    always_comb begin
        result    = 32'd0;
        carryFlag = 1'b0;
        case (opcode)
            OP_AND:  result = operandA & operandB;
            OP_ADD: begin
                result    = sum[31:0];
                carryFlag = sum[32];
            end
            OP_SUB, OP_CMP: begin
                result    = diff[31:0];
                carryFlag = diff[32];
            end
            OP_OR:   result = operandA | operandB;
            OP_XOR:  result = operandA ^ operandB;
            OP_SLL:  result = operandA << shamt;
            OP_SRL:  result = operandA >> shamt;
            OP_SRA:  result = $signed(operandA) >>> shamt;
            OP_PASS: result = operandB;
            OP_NOT:  result = ~operandA;
            default: result = 32'd0;
        endcase
    end

    // Result-derived flags and opcode-independent signed compare
    always_comb begin
        zeroFlag        = (result == 32'd0);
        negativeFlag    = result[31];
        greaterThanFlag = ($signed(operandA) > $signed(operandB));
        lessThanFlag    = ($signed(operandA) < $signed(operandB));
    end

    // Branch target: pc plus sign-extended offset, wrapping mod 2^32
    always_comb begin
        branchAddress = pc + {{16{imm[15]}}, imm};
    end

    // Registered copy of result every cycle; reset wins
    always_ff @(posedge clk) begin
        if (rst) begin
            ALUout <= 32'd0;
        end else begin
            ALUout <= result;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table plus register
// and reset sequences.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic [15:0] imm;
    logic [31:0] result;
    logic        zeroFlag;
    logic        carryFlag;
    logic        negativeFlag;
    logic        greaterThanFlag;
    logic        lessThanFlag;
    logic [31:0] ALUout;
    logic [31:0] branchAddress;

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec_unit dut (
        .clk(clk),
        .rst(rst),
        .operandA(operandA),
        .operandB(operandB),
        .opcode(opcode),
        .pc(pc),
        .imm(imm),
        .result(result),
        .zeroFlag(zeroFlag),
        .carryFlag(carryFlag),
        .negativeFlag(negativeFlag),
        .greaterThanFlag(greaterThanFlag),
        .lessThanFlag(lessThanFlag),
        .ALUout(ALUout),
        .branchAddress(branchAddress)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        n;
        logic        gt;
        logic        lt;
    } alu_vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [15:0] imm;
        logic [31:0] exp;
    } br_vec_t;

    alu_vec_t vecs[18];
    br_vec_t  brs[5];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'hFFFFFFFF, 32'h1,        6'd1,  32'h0,        1, 1, 0, 0, 1};
        vecs[1]  = '{32'h5,        32'h7,        6'd2,  32'hFFFFFFFE, 0, 1, 1, 0, 1};
        vecs[2]  = '{32'h5,        32'h7,        6'd8,  32'hFFFFFFFE, 0, 1, 1, 0, 1};
        vecs[3]  = '{32'h80000000, 32'h4,        6'd6,  32'h08000000, 0, 0, 0, 0, 1};
        vecs[4]  = '{32'h80000000, 32'h4,        6'd7,  32'hF8000000, 0, 0, 1, 0, 1};
        vecs[5]  = '{32'h80000000, 32'h20,       6'd5,  32'h80000000, 0, 0, 1, 0, 1};
        vecs[6]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 6'd0,  32'h00F000F0, 0, 0, 0, 0, 1};
        vecs[7]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 6'd3,  32'hFFF0FFF0, 0, 0, 1, 0, 1};
        vecs[8]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 6'd4,  32'hFF00FF00, 0, 0, 1, 0, 1};
        vecs[9]  = '{32'hF0F0F0F0, 32'h0FF00FF0, 6'd9,  32'h0FF00FF0, 0, 0, 0, 0, 1};
        vecs[10] = '{32'hF0F0F0F0, 32'h0FF00FF0, 6'd10, 32'h0F0F0F0F, 0, 0, 0, 0, 1};
        vecs[11] = '{32'h12345678, 32'h9ABCDEF0, 6'h3F, 32'h0,        1, 0, 0, 1, 0};
        vecs[12] = '{32'h7,        32'h7,        6'd2,  32'h0,        1, 0, 0, 0, 0};
        vecs[13] = '{32'h7FFFFFFF, 32'h1,        6'd1,  32'h80000000, 0, 0, 1, 1, 0};
        vecs[14] = '{32'h80000000, 32'h24,       6'd6,  32'h08000000, 0, 0, 0, 0, 1};
        vecs[15] = '{32'h1,        32'h2,        6'd11, 32'h0,        1, 0, 0, 0, 1};
        vecs[16] = '{32'h1,        32'h1F,       6'd5,  32'h80000000, 0, 0, 1, 0, 1};
        vecs[17] = '{32'h7,        32'h5,        6'd8,  32'h2,        0, 0, 0, 1, 0};

        brs[0] = '{32'h00000100, 16'hFFF0, 32'h000000F0};
        brs[1] = '{32'h00000100, 16'h0010, 32'h00000110};
        brs[2] = '{32'hFFFFFFFF, 16'h0001, 32'h00000000};
        brs[3] = '{32'h00000000, 16'hFFFF, 32'hFFFFFFFF};
        brs[4] = '{32'h00001000, 16'h8000, 32'hFFFF9000};

        rst      = 1'b1;
        operandA = 32'd0;
        operandB = 32'd0;
        opcode   = 6'd0;
        pc       = 32'd0;
        imm      = 16'd0;

        step();
        step();
        check("reset_aluout", ALUout, 32'h0);

        rst      = 1'b0;
        operandA = 32'd3;
        operandB = 32'd4;
        opcode   = 6'd1;
        #1;
        check("add_comb_result", result, 32'd7);
        step();
        check("aluout_load", ALUout, 32'd7);

        rst = 1'b1;
        pc  = 32'h100;
        imm = 16'h0010;
        step();
        check("aluout_midreset", ALUout, 32'h0);
        check("result_in_reset", result, 32'd7);
        check("branch_in_reset", branchAddress, 32'h110);

        rst = 1'b0;
        step();
        check("aluout_resume", ALUout, 32'd7);

        operandA = 32'd10;
        operandB = 32'd5;
        opcode   = 6'd2;
        #1;
        check("aluout_holds", ALUout, 32'd7);
        check("sub_comb", result, 32'd5);
        step();
        check("aluout_next", ALUout, 32'd5);

        operandA = 32'hDEADBEEF;
        operandB = 32'h12345678;
        opcode   = 6'h3F;
        step();
        check("aluout_undef", ALUout, 32'h0);

        for (int i = 0; i < 18; i++) begin
            operandA = vecs[i].a;
            operandB = vecs[i].b;
            opcode   = vecs[i].op;
            #2;
            check($sformatf("v%0d_result", i), result, vecs[i].res);
            check($sformatf("v%0d_flags{z,c,n,gt,lt}", i),
                  {27'd0, zeroFlag, carryFlag, negativeFlag,
                   greaterThanFlag, lessThanFlag},
                  {27'd0, vecs[i].z, vecs[i].c, vecs[i].n,
                   vecs[i].gt, vecs[i].lt});
        end

        for (int i = 0; i < 5; i++) begin
            pc  = brs[i].pc;
            imm = brs[i].imm;
            #2;
            check($sformatf("br%0d", i), branchAddress, brs[i].exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
